// File: rtl/divider_8bits_seq.sv
// divider_8bits_seq: sequential restoring divider, 2*WIDTH / WIDTH bits, one quotient bit per clock
module divider_8bits_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q;
  logic [WIDTH:0]     r_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dbz_q;
  logic               ovf_q;
  logic [WIDTH:0]     t_d;
  logic               ge_d;
  logic [WIDTH:0]     r_d;
  always_comb begin
    t_d  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    ge_d = t_d >= {1'b0, dvs_q};
    r_d  = ge_d ? t_d - {1'b0, dvs_q} : t_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dvs_q <= divisor;
          if (divisor == '0) begin
            state_q <= DONE;
            dbz_q   <= 1'b1;
            q_q     <= '1;
            r_q     <= {1'b0, dividend[WIDTH-1:0]};
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            state_q <= DONE;
            ovf_q   <= 1'b1;
            q_q     <= '1;
            r_q     <= '0;
          end else begin
            state_q <= CALC;
            r_q     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_q     <= dividend[WIDTH-1:0];
            cnt_q   <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= {q_q[WIDTH-2:0], ge_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: if (out_ready) begin
          state_q <= IDLE;
          dbz_q   <= 1'b0;
          ovf_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_divider_8bits_seq.sv
// tb_divider_8bits_seq: directed and randomized checks of divider_8bits_seq against an arithmetic model
module tb_divider_8bits_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;
  int          errors = 0;
  int          checks = 0;

  divider_8bits_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {dbz, ovf, q, r} from plain integer division
  function automatic logic [17:0] model(input int unsigned dd, input int unsigned dv);
    if (dv == 0) return {2'b10, 8'hFF, 8'(dd % 256)};
    if (dd / dv > 255) return {2'b01, 8'hFF, 8'h00};
    return {2'b00, 8'(dd / dv), 8'(dd % dv)};
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input logic eov, input int elat);
    int lat;
    accept(dd, dv);
    wait_valid(lat);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, edz);
    check({tag, "_ovf"}, overflow, eov);
    check({tag, "_in_ready_done"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_out_valid_clr"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    logic [17:0] m;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    rst = 1'b0;

    run_op("normal", 16'h3039, 8'h7B, 8'h64, 8'h2D, 0, 0, 9);
    run_op("max", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 0, 0, 9);
    run_op("dbz", 16'h1234, 8'h00, 8'hFF, 8'h34, 1, 0, 1);
    run_op("ovf", 16'h0100, 8'h01, 8'hFF, 8'h00, 0, 1, 1);
    run_op("near_ovf", 16'h00FF, 8'h01, 8'hFF, 8'h00, 0, 0, 9);
    run_op("ovf_eq", 16'h7B00, 8'h7B, 8'hFF, 8'h00, 0, 1, 1);

    out_ready = 1'b0;
    accept(16'h3039, 8'h7B);
    wait_valid(lat);
    check("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'h0100;
      divisor  = 8'h00;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 8'h64);
      check("bp_remainder", remainder, 8'h2D);
      check("bp_flags", {div_by_zero, overflow}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_valid_clr", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    @(negedge clk);
    check("bp_no_extra", out_valid, 0);

    accept(16'h3039, 8'h7B);
    repeat (3) @(negedge clk);
    check("mid_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_flags", {div_by_zero, overflow}, 0);
    run_op("after_rst", 16'h0064, 8'h0A, 8'h0A, 8'h00, 0, 0, 9);

    for (int i = 0; i < 1000; i++) begin
      int unsigned a, b, r;
      a = $urandom_range(1, 255);
      b = $urandom_range(1, 255);
      r = $urandom_range(0, b - 1);
      run_op("roundtrip", 16'(a * b + r), 8'(b), 8'(a), 8'(r), 0, 0, 9);
    end

    for (int i = 0; i < 200; i++) begin
      int unsigned dd, dv;
      dd = $urandom_range(0, 65535);
      dv = (i % 10 == 0) ? 0 : $urandom_range(1, 255);
      if (i % 7 == 0) dd = dd % (dv * 256 + 1);
      m = model(dd, dv);
      run_op("random", 16'(dd), 8'(dv), m[15:8], m[7:0], m[17], m[16],
             (m[17] | m[16]) ? 1 : 9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
